// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: control and status bundle for the BCD countdown timer
interface bcd_countdown_timer_if #(parameter int GROUPS = 2);
   logic                tick;
   logic                load;
   logic [8*GROUPS-1:0] load_value;
   logic                start;
   logic                pause_toggle;
   logic                dir;
   logic [8*GROUPS-1:0] digits;
   logic                running;
   logic                finished;
   logic                expired;
   modport master (
      output tick, load, load_value, start, pause_toggle, dir,
      input  digits, running, finished, expired
   );
   modport slave (
      input  tick, load, load_value, start, pause_toggle, dir,
      output digits, running, finished, expired
   );
endinterface

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: multi-group BCD up/down timer with pause, clamp-on-load and optional auto reload
module bcd_countdown_timer #(
   parameter int GROUPS      = 2,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input logic                  clk,
   input logic                  reset,
   bcd_countdown_timer_if.slave bus
);
   localparam int W = 8 * GROUPS;
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
   state_t         state;
   logic [W-1:0]   r;
   logic [W-1:0]   dig;
   logic [W-1:0]   step;
   logic [W-1:0]   term;
   logic           dir_q;
   logic           running;
   logic           finished;
   logic           expired;
   logic           reload;
   function automatic logic [3:0] tens_max(input int g);
      return (g == GROUPS - 1) ? 4'd9 : 4'd5;
   endfunction
   function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
      logic [3:0] u, t;
      clamp = v;
      for (int g = 0; g < GROUPS; g++) begin
         u = v[8*g +: 4];
         t = v[8*g+4 +: 4];
         clamp[8*g +: 4]   = (u > 4'd9) ? 4'd9 : u;
         clamp[8*g+4 +: 4] = (t > tens_max(g)) ? tens_max(g) : t;
      end
   endfunction
   function automatic logic [W-1:0] dec(input logic [W-1:0] v);
      logic [3:0] u, t;
      logic       b;
      dec = v;
      b   = 1'b1;
      for (int g = 0; g < GROUPS; g++) begin
         u = v[8*g +: 4];
         t = v[8*g+4 +: 4];
         if (b) begin
            if (u != 4'd0) begin
               u = u - 4'd1;
               b = 1'b0;
            end else begin
               u = 4'd9;
               if (t != 4'd0) begin
                  t = t - 4'd1;
                  b = 1'b0;
               end else
                  t = tens_max(g);
            end
         end
         dec[8*g +: 4]   = u;
         dec[8*g+4 +: 4] = t;
      end
   endfunction
   function automatic logic [W-1:0] inc(input logic [W-1:0] v);
      logic [3:0] u, t;
      logic       c;
      inc = v;
      c   = 1'b1;
      for (int g = 0; g < GROUPS; g++) begin
         u = v[8*g +: 4];
         t = v[8*g+4 +: 4];
         if (c) begin
            if (u != 4'd9) begin
               u = u + 4'd1;
               c = 1'b0;
            end else begin
               u = 4'd0;
               if (t != tens_max(g)) begin
                  t = t + 4'd1;
                  c = 1'b0;
               end else
                  t = 4'd0;
            end
         end
         inc[8*g +: 4]   = u;
         inc[8*g+4 +: 4] = t;
      end
   endfunction
   // next count value and the value that ends the current run
   always_comb begin
      step = dir_q ? inc(dig) : dec(dig);
      term = dir_q ? r : '0;
   end
   // control FSM; event priority is load, start, pause_toggle, tick
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= IDLE;
         r        <= '0;
         dig      <= '0;
         dir_q    <= 1'b0;
         running  <= 1'b0;
         finished <= 1'b0;
         expired  <= 1'b0;
         reload   <= 1'b0;
      end else begin
         finished <= 1'b0;
         if (bus.load) begin
            r       <= clamp(bus.load_value);
            dig     <= clamp(bus.load_value);
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
            reload  <= 1'b0;
         end else if (bus.start) begin
            if (state != RUN) begin
               dir_q    <= bus.dir;
               reload   <= 1'b0;
               dig      <= bus.dir ? '0 : r;
               state    <= (r == '0) ? DONE : RUN;
               running  <= r != '0;
               finished <= r == '0;
               expired  <= r == '0;
            end
         end else if (bus.pause_toggle) begin
            if (state == RUN) begin
               state   <= PAUSED;
               running <= 1'b0;
            end else if (state == PAUSED) begin
               state   <= RUN;
               running <= 1'b1;
            end
         end else if (bus.tick && state == RUN) begin
            if (reload) begin
               dig    <= dir_q ? '0 : r;
               reload <= 1'b0;
            end else begin
               dig <= step;
               if (step == term) begin
                  finished <= 1'b1;
                  if (AUTO_RELOAD)
                     reload <= 1'b1;
                  else begin
                     state   <= DONE;
                     running <= 1'b0;
                     expired <= 1'b1;
                  end
               end
            end
         end
      end
   assign bus.digits   = dig;
   assign bus.running  = running;
   assign bus.finished = finished;
   assign bus.expired  = expired;
endmodule
